// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU data-memory port: op encodings, FSM states,
// byte-space bound and the request legality check.
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LB  = 3'b001,
    OP_LBU = 3'b010,
    OP_LH  = 3'b011,
    OP_LHU = 3'b100,
    OP_SB  = 3'b101,
    OP_SH  = 3'b110,
    OP_SW  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam int ADDR_BITS   = 9;
  localparam int WORD_ADDR_W = ADDR_BITS - 2;

  function automatic logic is_store(input op_e op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Out of the 512-byte space, or not naturally aligned for its width.
  function automatic logic is_illegal(input op_e op, input logic [31:0] addr);
    logic bad;
    bad = |addr[31:ADDR_BITS];
    case (op)
      OP_LW, OP_SW:         bad = bad | (|addr[1:0]);
      OP_LH, OP_LHU, OP_SH: bad = bad | addr[0];
      default:              bad = bad;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_dm_port_if.sv
// CPU request/response and word-memory signals of the LSU data-memory port.
interface lsu_dm_port_if;
  import lsu_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  logic [2:0]             req_op;
  logic [31:0]            req_addr;
  logic [31:0]            req_wdata;
  logic                   rsp_valid;
  logic [31:0]            rsp_rdata;
  logic                   rsp_err;
  logic                   mem_we;
  logic [WORD_ADDR_W-1:0] mem_addr;
  logic [31:0]            mem_wdata;
  logic [31:0]            mem_rdata;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/lsu_align.sv
// Byte/half lane selection: extended load data and store merge word from one word.
module lsu_align
  import lsu_pkg::*;
(
  input  op_e         op,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = word[7:0];
    half_sel   = off[1] ? word[31:16] : word[15:0];
    load_data  = word;
    merge_data = wdata;

    case (off)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase

    case (op)
      OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {24'h0, byte_sel};
      OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data = {16'h0, half_sel};
      default: load_data = word;
    endcase

    // SW passes the full store word through; sub-word stores patch one lane.
    case (op)
      OP_SB: begin
        merge_data = word;
        case (off)
          2'd1:    merge_data[15:8]  = wdata[7:0];
          2'd2:    merge_data[23:16] = wdata[7:0];
          2'd3:    merge_data[31:24] = wdata[7:0];
          default: merge_data[7:0]   = wdata[7:0];
        endcase
      end
      OP_SH: begin
        merge_data = word;
        if (off[1]) merge_data[31:16] = wdata[15:0];
        else        merge_data[15:0]  = wdata[15:0];
      end
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_dm_port.sv
// Load/store unit port onto a 128-word memory with sub-word loads and
// read-modify-write sub-word stores.
module lsu_dm_port
  import lsu_pkg::*;
(
  input logic          clk,
  input logic          rst,
  lsu_dm_port_if.slave bus
);

  state_e               state, state_nx;
  op_e                  op_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [31:0]          wdata_q;
  logic [31:0]          merge_q;
  logic [31:0]          rdata_q;
  logic                 err_q;
  logic                 ready_en;

  logic        accept;
  logic        illegal;
  logic [31:0] align_word;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  assign illegal    = is_illegal(op_e'(bus.req_op), bus.req_addr);
  assign accept     = (state == IDLE) && ready_en && bus.req_valid;
  assign align_word = (state == WRITE) ? merge_q : bus.mem_rdata;

  lsu_align u_align (
    .op         (op_q),
    .off        (addr_q[1:0]),
    .word       (align_word),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = 32'h0;
    bus.rsp_err   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = 32'h0;

    case (state)
      IDLE: begin
        bus.req_ready = ready_en;
        if (accept) state_nx = illegal ? RESP : ACCESS;
      end
      ACCESS: begin
        bus.mem_addr = addr_q[ADDR_BITS-1:2];
        if (op_q == OP_SW) begin
          bus.mem_we    = 1'b1;
          bus.mem_wdata = merge_data;
        end
        state_nx = (op_q == OP_SB || op_q == OP_SH) ? WRITE : RESP;
      end
      WRITE: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = addr_q[ADDR_BITS-1:2];
        bus.mem_wdata = merge_data;
        state_nx      = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = err_q;
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // ready_en keeps req_ready low until the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en <= 1'b0;
      op_q     <= OP_LW;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      merge_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        op_q    <= op_e'(bus.req_op);
        addr_q  <= bus.req_addr[ADDR_BITS-1:0];
        wdata_q <= bus.req_wdata;
        err_q   <= illegal;
        rdata_q <= 32'h0;
        merge_q <= 32'h0;
      end else if (state == ACCESS) begin
        if (!is_store(op_q))                  rdata_q <= load_data;
        if (op_q == OP_SB || op_q == OP_SH)   merge_q <= bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_lsu_dm_port.sv
// Scoreboard bench for lsu_dm_port: reference memory model, expected responses
// and writes queued at acceptance, compared when the DUT produces them.
module tb_lsu_dm_port;

  localparam logic [2:0] T_LW = 3'd0, T_LB = 3'd1, T_LBU = 3'd2, T_LH = 3'd3;
  localparam logic [2:0] T_LHU = 3'd4, T_SB = 3'd5, T_SH = 3'd6, T_SW = 3'd7;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } rsp_t;

  typedef struct {
    logic [6:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic mon_en = 1'b0;

  logic [31:0] mem     [128];
  logic [31:0] ref_mem [128];
  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  rsp_t mon_r;
  wr_t  mon_w;

  lsu_dm_port_if bus ();

  lsu_dm_port dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got=%h want=%h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] expLoad(input logic [2:0] op, input logic [31:0] word, input logic [1:0] off);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (op)
      T_LB:    return {{24{sh[7]}}, sh[7:0]};
      T_LBU:   return {24'h0, sh[7:0]};
      T_LH:    return {{16{sh[15]}}, sh[15:0]};
      T_LHU:   return {16'h0, sh[15:0]};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] expMerge(input logic [2:0] op, input logic [31:0] word,
                                           input logic [31:0] wdata, input logic [1:0] off);
    logic [31:0] mask;
    logic [31:0] ins;
    if (op == T_SB) begin
      mask = 32'h0000_00FF << {off, 3'b000};
      ins  = (wdata & 32'h0000_00FF) << {off, 3'b000};
    end else begin
      mask = 32'h0000_FFFF << {off[1], 4'b0000};
      ins  = (wdata & 32'h0000_FFFF) << {off[1], 4'b0000};
    end
    return (word & ~mask) | ins;
  endfunction

  function automatic logic expIllegal(input logic [2:0] op, input logic [31:0] addr);
    if (addr >= 32'h200) return 1'b1;
    if ((op == T_LW || op == T_SW) && addr[1:0] != 2'b00) return 1'b1;
    if ((op == T_LH || op == T_LHU || op == T_SH) && addr[0]) return 1'b1;
    return 1'b0;
  endfunction

  // Leaves req_valid high on return so consecutive calls run back to back.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    int   waited;
    rsp_t r;
    wr_t  w;
    logic [31:0] word;
    waited = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    while (!bus.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) begin
      checkOutput("accept_timeout", {31'h0, bus.req_ready}, 32'h1);
      return;
    end
    r.acc   = cyc + 1;
    r.err   = expIllegal(op, addr);
    r.rdata = 32'h0;
    r.lat   = 1;
    if (!r.err) begin
      word = ref_mem[addr[8:2]];
      w.addr = addr[8:2];
      case (op)
        T_SW: begin
          ref_mem[addr[8:2]] = wdata;
          w.data = wdata;
          wr_q.push_back(w);
          r.lat = 2;
        end
        T_SB, T_SH: begin
          ref_mem[addr[8:2]] = expMerge(op, word, wdata, addr[1:0]);
          w.data = ref_mem[addr[8:2]];
          wr_q.push_back(w);
          r.lat = 3;
        end
        default: begin
          r.rdata = expLoad(op, word, addr[1:0]);
          r.lat   = 2;
        end
      endcase
    end
    rsp_q.push_back(r);
    @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.rsp_valid) begin
        checkOutput("ready_in_resp", {31'h0, bus.req_ready}, 32'h0);
        if (rsp_q.size() == 0) begin
          checkOutput("rsp_unexpected", {31'h0, bus.rsp_valid}, 32'h0);
        end else begin
          mon_r = rsp_q.pop_front();
          checkOutput("rsp_rdata", bus.rsp_rdata, mon_r.rdata);
          checkOutput("rsp_err", {31'h0, bus.rsp_err}, {31'h0, mon_r.err});
          checkOutput("rsp_latency", cyc - mon_r.acc + 1, mon_r.lat);
        end
      end else begin
        checkOutput("rdata_quiet", bus.rsp_rdata, 32'h0);
        checkOutput("err_quiet", {31'h0, bus.rsp_err}, 32'h0);
      end
      if (bus.mem_we) begin
        checkOutput("ready_in_write", {31'h0, bus.req_ready}, 32'h0);
        if (wr_q.size() == 0) begin
          checkOutput("we_unexpected", {31'h0, bus.mem_we}, 32'h0);
        end else begin
          mon_w = wr_q.pop_front();
          checkOutput("we_addr", {25'h0, bus.mem_addr}, {25'h0, mon_w.addr});
          checkOutput("we_data", bus.mem_wdata, mon_w.data);
        end
      end
      if (bus.req_ready) begin
        checkOutput("idle_mem_addr", {25'h0, bus.mem_addr}, 32'h0);
        checkOutput("idle_mem_wdata", bus.mem_wdata, 32'h0);
      end
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ready"}, {31'h0, bus.req_ready}, 32'h0);
    checkOutput({tag, "_rsp_valid"}, {31'h0, bus.rsp_valid}, 32'h0);
    checkOutput({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'h0);
    checkOutput({tag, "_rsp_err"}, {31'h0, bus.rsp_err}, 32'h0);
    checkOutput({tag, "_mem_we"}, {31'h0, bus.mem_we}, 32'h0);
    checkOutput({tag, "_mem_addr"}, {25'h0, bus.mem_addr}, 32'h0);
    checkOutput({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
  endtask

  task automatic drain(input string tag);
    int waited;
    waited = 0;
    while ((rsp_q.size() != 0 || wr_q.size() != 0) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, "_rsp_left"}, rsp_q.size(), 32'h0);
    checkOutput({tag, "_wr_left"}, wr_q.size(), 32'h0);
  endtask

  initial begin
    logic [31:0] saved;
    logic [2:0]  op;
    logic [31:0] addr;
    int          waited;

    for (int i = 0; i < 128; i++) begin
      mem[i]     = 32'hA5A5_0000 ^ (i * 32'h0101_0137);
      ref_mem[i] = mem[i];
    end
    mem[4] = 32'h8899_AABB;  ref_mem[4] = 32'h8899_AABB;
    mem[8] = 32'h1122_3344;  ref_mem[8] = 32'h1122_3344;

    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;

    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;
    #1 checkOutput("ready_before_edge", {31'h0, bus.req_ready}, 32'h0);
    @(posedge clk);
    #1 checkOutput("ready_after_edge", {31'h0, bus.req_ready}, 32'h1);
    mon_en = 1'b1;

    applyStimulus(T_LB,  32'h11,  32'h0);
    applyStimulus(T_LHU, 32'h12,  32'h0);
    applyStimulus(T_LH,  32'h12,  32'h0);
    applyStimulus(T_LW,  32'h10,  32'h0);
    applyStimulus(T_LBU, 32'h10,  32'h0);
    applyStimulus(T_SB,  32'h23,  32'hFFFF_FF5A);
    applyStimulus(T_LW,  32'h20,  32'h0);
    applyStimulus(T_SH,  32'h22,  32'h1234_BEEF);
    applyStimulus(T_LW,  32'h20,  32'h0);
    applyStimulus(T_SW,  32'h1FC, 32'hDEAD_BEEF);
    applyStimulus(T_LH,  32'h1FE, 32'h0);
    applyStimulus(T_LB,  32'h1FF, 32'h0);
    applyStimulus(T_SW,  32'h06,  32'h0BAD_0BAD);
    applyStimulus(T_LH,  32'h201, 32'h0);
    applyStimulus(T_LB,  32'h200, 32'h0);
    applyStimulus(T_SB,  32'h8000_0010, 32'h77);

    for (int i = 0; i < 40; i++) begin
      op   = 3'($urandom_range(0, 7));
      addr = 32'($urandom_range(0, 511));
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) addr[31:9] = 23'($urandom_range(1, 4096));
      applyStimulus(op, addr, $urandom);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    drain("main");

    for (int i = 0; i < 128; i++)
      checkOutput("mem_image", mem[i], ref_mem[i]);

    // Abort an SH in WRITE: nothing is queued, so any write or response fails.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = T_SH;
    bus.req_addr  = 32'h22;
    bus.req_wdata = 32'h0000_CAFE;
    waited = 0;
    while (!bus.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("abort_accept", {31'h0, bus.req_ready}, 32'h1);
    saved = mem[8];
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkResetOutputs("abort");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("abort_ready_pre", {31'h0, bus.req_ready}, 32'h0);
    @(posedge clk);
    #1 checkOutput("abort_ready_post", {31'h0, bus.req_ready}, 32'h1);
    checkOutput("abort_mem_unchanged", mem[8], saved);

    applyStimulus(T_LHU, 32'h22, 32'h0);
    applyStimulus(T_SB,  32'h21, 32'h0000_00C3);
    applyStimulus(T_LW,  32'h20, 32'h0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    drain("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got=running want=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/lsu_dm_port.md
LSU_DM_PORT -- requirements
Module: lsu_dm_port

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
REQ-002 The CPU-side ports SHALL be:
- req_valid  input  1  request present
- req_ready  output  1  request accepted this cycle when high with req_valid
- req_op  input  3  LW=000, LB=001, LBU=010, LH=011, LHU=100, SB=101, SH=110, SW=111
- req_addr  input  32  byte address
- req_wdata  input  32  store data, low bits used for SB/SH
- rsp_valid  output  1  one-cycle response pulse
- rsp_rdata  output  32  extended load data; 0 for stores and errors
- rsp_err  output  1  request rejected (misaligned or out of range)
REQ-003 The memory-side ports SHALL be:
- mem_we  output  1  word write strobe
- mem_addr  output  7  word address, equal to byte address bits [8:2]
- mem_wdata  output  32  full word to write
- mem_rdata  input  32  combinational read of word at mem_addr

Function
REQ-004 The FSM SHALL use states IDLE, ACCESS, WRITE and RESP.
REQ-005 req_ready SHALL be 1 only in IDLE.
REQ-006 On acceptance (IDLE, req_valid=1), the block SHALL latch op, addr and wdata and move to ACCESS; if the request is illegal it SHALL move to RESP instead.
REQ-007 A request SHALL be illegal when any of the following holds:
- req_addr[31:9] is nonzero
- LW/SW with addr[1:0] not 00
- LH/LHU/SH with addr[0]=1
REQ-008 In ACCESS, mem_addr SHALL equal latched addr[8:2].
REQ-009 In ACCESS, each op class SHALL behave as follows:
- Loads: latch the extracted, extended data; next state RESP.
- SW: mem_we=1, mem_wdata=wdata; next state RESP.
- SB/SH: latch mem_rdata as the merge word; next state WRITE.
REQ-010 In WRITE, mem_we SHALL be 1 and mem_wdata SHALL be the merge word with the byte lane (addr[1:0]) or half lane (addr[1]) replaced by wdata[7:0] or wdata[15:0]; next state RESP.
REQ-011 In RESP, rsp_valid SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-012 rsp_valid SHALL not wait on the CPU; there is no response backpressure.
REQ-013 Load extraction SHALL use addr[1:0] for LB/LBU and addr[1] for LH/LHU.
REQ-014 LB and LH SHALL sign-extend to 32 bits (24 and 16 copies of the MSB); LBU and LHU SHALL zero-extend.
REQ-015 Latency SHALL be counted from the accepting edge:
- loads and SW: rsp_valid in the 2nd cycle
- SB/SH: rsp_valid in the 3rd cycle
- illegal requests: rsp_valid in the 1st cycle
REQ-016 mem_we SHALL be 0 in IDLE, RESP and ACCESS except for SW, and SHALL never assert for an illegal request.
REQ-017 mem_addr and mem_wdata SHALL be 0 in IDLE.
REQ-018 rsp_rdata and rsp_err SHALL hold their values while rsp_valid=1 and be 0 otherwise.

Reset
REQ-019 While rst=1, the FSM SHALL be IDLE and all outputs and latched registers SHALL be 0, except req_ready=0.
REQ-020 Reset asserted in ACCESS or WRITE SHALL abort the operation: no mem_we pulse and no rsp_valid.
REQ-021 After reset deasserts, req_ready SHALL be 1 from the next clock edge.

Structure
REQ-022 Package lsu_pkg SHALL hold the op encodings, the state enum and the illegal-address bound (9-bit byte space).
REQ-023 Lane selection and extension SHALL be a combinational sub-module lsu_align, shared by the load path and the store merge.

Verification
REQ-024 Memory word 0x10 = 0x8899AABB; LB at 0x11 -> rsp_rdata=0xFFFFFFAA, rsp_err=0, rsp_valid 2 cycles after acceptance.
REQ-025 Same word; LHU at 0x12 -> rsp_rdata=0x00008899; LH at 0x12 -> rsp_rdata=0xFFFF8899.
REQ-026 Word 0x20 = 0x11223344; SB at 0x23 with wdata=0xFFFFFF5A -> one mem_we pulse in WRITE with mem_wdata=0x5A223344, mem_addr=0x08, rsp_valid 3 cycles after acceptance.
REQ-027 SW at 0x06 and LH at 0x201 -> rsp_err=1, rsp_rdata=0, mem_we never asserted, rsp_valid 1 cycle after acceptance.
REQ-028 Reset pulsed during WRITE of an SH -> no mem_we, no rsp_valid, memory word unchanged, req_ready=1 after release.
REQ-029 Back-to-back req_valid held high -> req_ready low outside IDLE; each request is accepted only in IDLE and receives exactly one response.
